// File: rtl/rbc_pkg.sv
// Shared definitions for the register bank write controller.
//   - State encoding and state enum for the controller FSM.
//   - clog2 helper used to size the round-robin pointer.
package rbc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE,
        CLEAR = ST_CLEAR
    } state_t;

    // Smallest w with 2**w >= value, never less than 1 so a pointer
    // always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rbc_rr_arbiter.sv
// Combinational round-robin winner selection.
// Searches req starting at rr_ptr+1 and wrapping modulo N_REQ; the first
// asserted requester wins.
// Ports:
//   req     in  N_REQ  request vector
//   rr_ptr  in  PTR_W  index of the last requester granted
//   winner  out N_REQ  one-hot winner (all zero when no request)
//   valid   out 1      at least one request present
module rbc_rr_arbiter
    import rbc_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    int idx;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Write controller for a bank of N_REG Reg cells sharing one write path.
// Round-robin arbitration between N_REQ requesters, plus a bank-wide
// clear sequenced through its own state. One write per two cycles peak.
// Optional macro RBC_ADDR_CHECK_EN adds a sticky err_addr output that
// flags any granted write whose address is >= N_REG.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   req         in   N_REQ level requests, held until granted
//   req_addr    in   flattened addresses, requester i at [i*SIZEADDR +: SIZEADDR]
//   req_data    in   flattened data, requester i at [i*SIZEDATA +: SIZEDATA]
//   clear_all   in   one-cycle bank clear request
//   gnt         out  one-hot, one-cycle grant
//   reg_enable  out  one-hot write enable per register
//   reg_clear   out  shared clear to all registers
//   reg_datain  out  shared write data, holds when not writing
//   busy        out  state not IDLE or a clear pending
//   err_addr    out  (RBC_ADDR_CHECK_EN only) sticky bad-address flag
module reg_bank_ctrl
    import rbc_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int N_REG    = 8,
    parameter int SIZEDATA = 32,
    parameter int SIZEADDR = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*SIZEADDR-1:0]    req_addr,
    input  logic [N_REQ*SIZEDATA-1:0]    req_data,
    input  logic                         clear_all,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REG-1:0]             reg_enable,
    output logic                         reg_clear,
    output logic [SIZEDATA-1:0]          reg_datain,
    output logic                         busy
`ifdef RBC_ADDR_CHECK_EN
    ,
    output logic                         err_addr
`endif
);

    localparam int PTR_W = clog2(N_REQ);

    state_t               state_q, state_n;
    logic                 clear_pend_q, clear_pend_n;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_n;

    logic [N_REQ-1:0]     gnt_n;
    logic [N_REG-1:0]     reg_enable_n;
    logic                 reg_clear_n;
    logic [SIZEDATA-1:0]  reg_datain_n;
    logic                 busy_n;
`ifdef RBC_ADDR_CHECK_EN
    logic                 err_addr_n;
`endif

    logic [N_REQ-1:0]     win_oh;
    logic                 win_valid;
    logic [PTR_W-1:0]     win_idx;
    logic [SIZEADDR-1:0]  win_addr;
    logic [SIZEDATA-1:0]  win_data;

    rbc_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (win_oh),
        .valid  (win_valid)
    );

    // Mux the winner's index, address and data out of the flattened buses.
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = PTR_W'(i);
                win_addr = req_addr[i*SIZEADDR +: SIZEADDR];
                win_data = req_data[i*SIZEDATA +: SIZEDATA];
            end
        end
    end

    always_comb begin
        state_n      = state_q;
        clear_pend_n = clear_pend_q;
        rr_ptr_n     = rr_ptr_q;
        gnt_n        = '0;
        reg_enable_n = '0;
        reg_clear_n  = 1'b0;
        reg_datain_n = reg_datain;
`ifdef RBC_ADDR_CHECK_EN
        err_addr_n   = err_addr;
`endif
        case (state_q)
            IDLE: begin
                // A clear (new or deferred) beats any write request and
                // leaves the round-robin pointer untouched.
                if (clear_all || clear_pend_q) begin
                    state_n      = CLEAR;
                    reg_clear_n  = 1'b1;
                    clear_pend_n = 1'b0;
                end else if (win_valid) begin
                    state_n      = WRITE;
                    gnt_n        = win_oh;
                    reg_datain_n = win_data;
                    rr_ptr_n     = win_idx;
                    // Out-of-range addresses match no register: the grant
                    // still goes out but the write is dropped.
                    for (int k = 0; k < N_REG; k++) begin
                        reg_enable_n[k] = (int'(win_addr) == k);
                    end
`ifdef RBC_ADDR_CHECK_EN
                    if (int'(win_addr) >= N_REG) begin
                        err_addr_n = 1'b1;
                    end
`endif
                end
            end
            // req is not sampled here, so a requester still holding req
            // during its grant cycle is never granted twice.
            WRITE, CLEAR: begin
                state_n = IDLE;
                if (clear_all) begin
                    clear_pend_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE) || clear_pend_n;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            clear_pend_q <= 1'b0;
            rr_ptr_q     <= PTR_W'(N_REQ - 1);
            gnt          <= '0;
            reg_enable   <= '0;
            reg_clear    <= 1'b0;
            reg_datain   <= '0;
            busy         <= 1'b0;
`ifdef RBC_ADDR_CHECK_EN
            err_addr     <= 1'b0;
`endif
        end else begin
            state_q      <= state_n;
            clear_pend_q <= clear_pend_n;
            rr_ptr_q     <= rr_ptr_n;
            gnt          <= gnt_n;
            reg_enable   <= reg_enable_n;
            reg_clear    <= reg_clear_n;
            reg_datain   <= reg_datain_n;
            busy         <= busy_n;
`ifdef RBC_ADDR_CHECK_EN
            err_addr     <= err_addr_n;
`endif
        end
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed testbench for reg_bank_ctrl (N_REQ=4, N_REG=6, SIZEADDR=3).
// Inputs change and outputs are checked on the falling clock edge.
// Control outputs are compared as one vector {gnt, reg_enable, reg_clear, busy}.
module tb_reg_bank_ctrl;

    localparam int N_REQ    = 4;
    localparam int N_REG    = 6;
    localparam int SIZEDATA = 32;
    localparam int SIZEADDR = 3;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [N_REQ-1:0]            req = '0;
    logic [SIZEADDR-1:0]         addr [N_REQ];
    logic [SIZEDATA-1:0]         data [N_REQ];
    logic [N_REQ*SIZEADDR-1:0]   req_addr;
    logic [N_REQ*SIZEDATA-1:0]   req_data;
    logic                        clear_all = 1'b0;
    logic [N_REQ-1:0]            gnt;
    logic [N_REG-1:0]            reg_enable;
    logic                        reg_clear;
    logic [SIZEDATA-1:0]         reg_datain;
    logic                        busy;
`ifdef RBC_ADDR_CHECK_EN
    logic                        err_addr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    assign req_addr = {addr[3], addr[2], addr[1], addr[0]};
    assign req_data = {data[3], data[2], data[1], data[0]};

    always #5 clk = ~clk;

    reg_bank_ctrl #(
        .N_REQ    (N_REQ),
        .N_REG    (N_REG),
        .SIZEDATA (SIZEDATA),
        .SIZEADDR (SIZEADDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .clear_all  (clear_all),
        .gnt        (gnt),
        .reg_enable (reg_enable),
        .reg_clear  (reg_clear),
        .reg_datain (reg_datain),
        .busy       (busy)
`ifdef RBC_ADDR_CHECK_EN
        ,
        .err_addr   (err_addr)
`endif
    );

    task automatic apply_reset();
        reset     = 1'b1;
        req       = '0;
        clear_all = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0000_000000_0_0) begin
            n_errors++;
            $display("FAIL reset_ctl: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0000_000000_0_0);
        end
        n_checks++;
        if (reg_datain !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_datain: got %h expected %h", reg_datain, 32'h0);
        end
`ifdef RBC_ADDR_CHECK_EN
        n_checks++;
        if (err_addr !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_err_addr: got %b expected %b", err_addr, 1'b0);
        end
`endif
    endtask

    task automatic test_single_write();
        addr[0] = 3'd3;
        data[0] = 32'hA5A5_0001;
        req     = 4'b0001;
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0001_001000_0_1) begin
            n_errors++;
            $display("FAIL single_grant: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0001_001000_0_1);
        end
        n_checks++;
        if (reg_datain !== 32'hA5A5_0001) begin
            n_errors++;
            $display("FAIL single_datain: got %h expected %h", reg_datain, 32'hA5A5_0001);
        end
        req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0000_000000_0_0) begin
            n_errors++;
            $display("FAIL single_release: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0000_000000_0_0);
        end
        n_checks++;
        if (reg_datain !== 32'hA5A5_0001) begin
            n_errors++;
            $display("FAIL single_datain_hold: got %h expected %h", reg_datain, 32'hA5A5_0001);
        end
    endtask

    // All four requesters held: grants 0,1,2,3,0 on odd cycles, idle between.
    task automatic test_round_robin();
        int              idx;
        logic [11:0]     exp_ctl;
        apply_reset();
        for (int i = 0; i < N_REQ; i++) begin
            addr[i] = SIZEADDR'(i + 1);
            data[i] = 32'h1000_0000 + 32'(i);
        end
        req = 4'b1111;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            idx = ((c - 1) / 2) % 4;
            if (c % 2 == 1) begin
                exp_ctl = {4'(1 << idx), 6'(1 << (idx + 1)), 1'b0, 1'b1};
            end else begin
                exp_ctl = 12'b0000_000000_0_0;
            end
            n_checks++;
            if ({gnt, reg_enable, reg_clear, busy} !== exp_ctl) begin
                n_errors++;
                $display("FAIL rr_cycle%0d: got %b expected %b", c, {gnt, reg_enable, reg_clear, busy}, exp_ctl);
            end
            if (c % 2 == 1) begin
                n_checks++;
                if (reg_datain !== 32'h1000_0000 + 32'(idx)) begin
                    n_errors++;
                    $display("FAIL rr_datain%0d: got %h expected %h", c, reg_datain, 32'h1000_0000 + 32'(idx));
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_clear_vs_req();
        addr[1]   = 3'd2;
        data[1]   = 32'h0000_00C1;
        clear_all = 1'b1;
        req       = 4'b0010;
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0000_000000_1_1) begin
            n_errors++;
            $display("FAIL clrreq_clear: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0000_000000_1_1);
        end
        clear_all = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0000_000000_0_0) begin
            n_errors++;
            $display("FAIL clrreq_gap: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0000_000000_0_0);
        end
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0010_000100_0_1) begin
            n_errors++;
            $display("FAIL clrreq_grant: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0010_000100_0_1);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    // Pulse in WRITE and pulse in CLEAR: two separate one-cycle clears.
    task automatic test_clear_during_write();
        logic [11:0] exp_seq [7];
        exp_seq[0] = 12'b0000_000000_0_1;   // back in IDLE, clear pending
        exp_seq[1] = 12'b0000_000000_1_1;   // first CLEAR
        exp_seq[2] = 12'b0000_000000_0_1;   // IDLE, second clear pending
        exp_seq[3] = 12'b0000_000000_1_1;   // second CLEAR
        exp_seq[4] = 12'b0000_000000_0_0;
        exp_seq[5] = 12'b0000_000000_0_0;
        exp_seq[6] = 12'b0000_000000_0_0;
        addr[2] = 3'd5;
        data[2] = 32'hBEEF_0002;
        req     = 4'b0100;
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0100_100000_0_1) begin
            n_errors++;
            $display("FAIL cdw_grant: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0100_100000_0_1);
        end
        req       = 4'b0000;
        clear_all = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            clear_all = (c == 1);
            n_checks++;
            if ({gnt, reg_enable, reg_clear, busy} !== exp_seq[c]) begin
                n_errors++;
                $display("FAIL cdw_step%0d: got %b expected %b", c, {gnt, reg_enable, reg_clear, busy}, exp_seq[c]);
            end
        end
        clear_all = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        addr[2] = 3'd1;
        data[2] = 32'h5555_0002;
        req     = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_errors++;
            $display("FAIL rst_setup_grant: got %b expected %b", gnt, 4'b0100);
        end
        reset     = 1'b1;
        clear_all = 1'b1;
        req       = 4'b0000;
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0000_000000_0_0) begin
            n_errors++;
            $display("FAIL rst_abort: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0000_000000_0_0);
        end
        n_checks++;
        if (reg_datain !== 32'h0) begin
            n_errors++;
            $display("FAIL rst_datain: got %h expected %h", reg_datain, 32'h0);
        end
        reset     = 1'b0;
        clear_all = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({reg_clear, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_no_clear: got %b expected %b", {reg_clear, busy}, 2'b00);
        end
        addr[0] = 3'd0;
        data[0] = 32'h0000_000A;
        addr[3] = 3'd4;
        data[3] = 32'h0000_000D;
        req     = 4'b1001;
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0001_000001_0_1) begin
            n_errors++;
            $display("FAIL rst_ptr_reload: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0001_000001_0_1);
        end
        n_checks++;
        if (reg_datain !== 32'h0000_000A) begin
            n_errors++;
            $display("FAIL rst_ptr_datain: got %h expected %h", reg_datain, 32'h0000_000A);
        end
        req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b1000_010000_0_1) begin
            n_errors++;
            $display("FAIL rst_next_grant: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b1000_010000_0_1);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    // Address 7 with N_REG=6: grant issued, no enable, optional sticky error.
    task automatic test_addr_range();
`ifdef RBC_ADDR_CHECK_EN
        n_checks++;
        if (err_addr !== 1'b0) begin
            n_errors++;
            $display("FAIL addr_err_before: got %b expected %b", err_addr, 1'b0);
        end
`endif
        addr[0] = 3'd7;
        data[0] = 32'hDEAD_0007;
        req     = 4'b0001;
        @(negedge clk);
        n_checks++;
        if ({gnt, reg_enable, reg_clear, busy} !== 12'b0001_000000_0_1) begin
            n_errors++;
            $display("FAIL addr_drop: got %b expected %b", {gnt, reg_enable, reg_clear, busy}, 12'b0001_000000_0_1);
        end
`ifdef RBC_ADDR_CHECK_EN
        n_checks++;
        if (err_addr !== 1'b1) begin
            n_errors++;
            $display("FAIL addr_err_set: got %b expected %b", err_addr, 1'b1);
        end
`endif
        req       = 4'b0000;
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        n_checks++;
        if (reg_clear !== 1'b1) begin
            n_errors++;
            $display("FAIL addr_clear: got %b expected %b", reg_clear, 1'b1);
        end
        @(negedge clk);
`ifdef RBC_ADDR_CHECK_EN
        n_checks++;
        if (err_addr !== 1'b1) begin
            n_errors++;
            $display("FAIL addr_err_sticky: got %b expected %b", err_addr, 1'b1);
        end
        apply_reset();
        n_checks++;
        if (err_addr !== 1'b0) begin
            n_errors++;
            $display("FAIL addr_err_reset: got %b expected %b", err_addr, 1'b0);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            addr[i] = '0;
            data[i] = '0;
        end
        test_reset();
        test_single_write();
        test_round_robin();
        test_clear_vs_req();
        test_clear_during_write();
        test_reset_mid_write();
        test_addr_range();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
